morse_word_decoder_hs: RTL and testbench

Parametrised next-generation Morse word receiver. It samples a raw on/off keying line on clock-enable ticks and classifies each mark as a dit or a dah against programmable times and a tolerance. Marks are assembled into characters and characters into words, and each finished word is handed downstream over a valid/ready handshake with length and status flags. It sits between the keying-input conditioning and the text/UART formatting stage. It replaces the fixed-size capture-and-decode word block, adding:

- parametrised word depth and counter width
- an output handshake with drop detection
- per-word overflow and error status
- autonomous word-end timeout

---
 rtl/morse_word_decoder_hs_pkg.sv | 80 ++++++++
 rtl/morse_pattern_to_char.sv | 26 ++
 rtl/morse_word_decoder_hs.sv | 254 +++++++++++++++++++++++++
 tb/tb_morse_word_decoder_hs.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_word_decoder_hs_pkg.sv
// Shared definitions for the Morse word receiver: character codes, FSM encoding and
// the pattern-to-character table (dit = 0, dah = 1, first symbol in the MSB of the pattern).
package morse_word_decoder_hs_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam logic [CHAR_W-1:0] CHAR_NONE = 8'h00;

    localparam logic [CHAR_W-1:0] CHAR_MORSE_A = 8'h41;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_B = 8'h42;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_C = 8'h43;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_D = 8'h44;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_E = 8'h45;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_F = 8'h46;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_G = 8'h47;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_H = 8'h48;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_I = 8'h49;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_J = 8'h4a;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_K = 8'h4b;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_L = 8'h4c;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_M = 8'h4d;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_N = 8'h4e;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_O = 8'h4f;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_P = 8'h50;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_Q = 8'h51;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_R = 8'h52;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_S = 8'h53;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_T = 8'h54;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_U = 8'h55;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_V = 8'h56;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_W = 8'h57;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_X = 8'h58;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_Y = 8'h59;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_Z = 8'h5a;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_0 = 8'h30;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_1 = 8'h31;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_2 = 8'h32;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_3 = 8'h33;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_4 = 8'h34;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_5 = 8'h35;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_6 = 8'h36;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_7 = 8'h37;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_8 = 8'h38;
    localparam logic [CHAR_W-1:0] CHAR_MORSE_9 = 8'h39;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMark  = 2'd1,
        StSpace = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]        len;
        logic [4:0]        pat;
        logic [CHAR_W-1:0] code;
    } morse_entry_t;

    localparam int unsigned MORSE_ENTRIES = 36;

    localparam morse_entry_t MORSE_TABLE [MORSE_ENTRIES] = '{
        {3'd2, 5'b00001, CHAR_MORSE_A}, {3'd4, 5'b01000, CHAR_MORSE_B},
        {3'd4, 5'b01010, CHAR_MORSE_C}, {3'd3, 5'b00100, CHAR_MORSE_D},
        {3'd1, 5'b00000, CHAR_MORSE_E}, {3'd4, 5'b00010, CHAR_MORSE_F},
        {3'd3, 5'b00110, CHAR_MORSE_G}, {3'd4, 5'b00000, CHAR_MORSE_H},
        {3'd2, 5'b00000, CHAR_MORSE_I}, {3'd4, 5'b00111, CHAR_MORSE_J},
        {3'd3, 5'b00101, CHAR_MORSE_K}, {3'd4, 5'b00100, CHAR_MORSE_L},
        {3'd2, 5'b00011, CHAR_MORSE_M}, {3'd2, 5'b00010, CHAR_MORSE_N},
        {3'd3, 5'b00111, CHAR_MORSE_O}, {3'd4, 5'b00110, CHAR_MORSE_P},
        {3'd4, 5'b01101, CHAR_MORSE_Q}, {3'd3, 5'b00010, CHAR_MORSE_R},
        {3'd3, 5'b00000, CHAR_MORSE_S}, {3'd1, 5'b00001, CHAR_MORSE_T},
        {3'd3, 5'b00001, CHAR_MORSE_U}, {3'd4, 5'b00001, CHAR_MORSE_V},
        {3'd3, 5'b00011, CHAR_MORSE_W}, {3'd4, 5'b01001, CHAR_MORSE_X},
        {3'd4, 5'b01011, CHAR_MORSE_Y}, {3'd4, 5'b01100, CHAR_MORSE_Z},
        {3'd5, 5'b11111, CHAR_MORSE_0}, {3'd5, 5'b01111, CHAR_MORSE_1},
        {3'd5, 5'b00111, CHAR_MORSE_2}, {3'd5, 5'b00011, CHAR_MORSE_3},
        {3'd5, 5'b00001, CHAR_MORSE_4}, {3'd5, 5'b00000, CHAR_MORSE_5},
        {3'd5, 5'b10000, CHAR_MORSE_6}, {3'd5, 5'b11000, CHAR_MORSE_7},
        {3'd5, 5'b11100, CHAR_MORSE_8}, {3'd5, 5'b11110, CHAR_MORSE_9}
    };

endpackage

// File: rtl/morse_pattern_to_char.sv
// Combinational lookup of a dit/dah pattern plus symbol count into a character code.
// Shared with the transmitter side, so it carries no state.
module morse_pattern_to_char
    import morse_word_decoder_hs_pkg::*;
#(
    parameter int unsigned MAX_SYMBOLS = 6
) (
    input  logic [MAX_SYMBOLS-1:0]         pattern,
    input  logic [$clog2(MAX_SYMBOLS+1)-1:0] count,
    output logic [CHAR_W-1:0]              char_code,
    output logic                           valid
);

    always_comb begin
        char_code = CHAR_NONE;
        valid     = 1'b0;
        for (int i = 0; i < MORSE_ENTRIES; i++) begin
            if ((32'(count) == 32'(MORSE_TABLE[i].len)) &&
                (32'(pattern) == 32'(MORSE_TABLE[i].pat))) begin
                char_code = MORSE_TABLE[i].code;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_word_decoder_hs.sv
// Morse word receiver: classifies marks into dits/dahs, assembles characters and words,
// and hands each finished word downstream through a single valid/ready holding register.
module morse_word_decoder_hs
    import morse_word_decoder_hs_pkg::*;
#(
    parameter int unsigned PULSE_CNT_W = 16,
    parameter int unsigned MAX_CHARS   = 16,
    parameter int unsigned MAX_SYMBOLS = 6,
    localparam int unsigned LEN_W      = $clog2(MAX_CHARS + 1),
    localparam int unsigned WORD_W     = CHAR_W * MAX_CHARS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   signal,
    input  logic [PULSE_CNT_W-1:0] dit_time,
    input  logic [PULSE_CNT_W-1:0] dah_time,
    input  logic [PULSE_CNT_W-1:0] word_time,
    input  logic [PULSE_CNT_W-1:0] tol_time,
    output logic [WORD_W-1:0]      word,
    output logic [LEN_W-1:0]       word_len,
    output logic                   word_err,
    output logic                   word_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   dropped
);

    localparam int unsigned SYM_W = $clog2(MAX_SYMBOLS + 1);

    function automatic logic [PULSE_CNT_W-1:0] sat_inc(input logic [PULSE_CNT_W-1:0] v);
        return (&v) ? v : v + PULSE_CNT_W'(1);
    endfunction

    function automatic logic [PULSE_CNT_W:0] abs_diff(input logic [PULSE_CNT_W-1:0] a,
                                                      input logic [PULSE_CNT_W-1:0] b);
        logic [PULSE_CNT_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[PULSE_CNT_W] ? ({1'b0, b} - {1'b0, a}) : d;
    endfunction

    // A threshold that would be zero or negative fires on the first gap tick instead.
    function automatic logic [PULSE_CNT_W-1:0] gap_thr(input logic [PULSE_CNT_W-1:0] a,
                                                       input logic [PULSE_CNT_W-1:0] b);
        return (a > b) ? a - b : PULSE_CNT_W'(1);
    endfunction

    state_e                 state_q, state_d;
    logic [PULSE_CNT_W-1:0] mark_cnt_q, mark_cnt_d;
    logic [PULSE_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [MAX_SYMBOLS-1:0] pat_q, pat_d;
    logic [SYM_W-1:0]       sym_cnt_q, sym_cnt_d;
    logic                   char_err_q, char_err_d;
    logic [WORD_W-1:0]      acc_word_q, acc_word_d;
    logic [LEN_W-1:0]       acc_len_q, acc_len_d;
    logic                   acc_err_q, acc_err_d;
    logic                   acc_ovf_q, acc_ovf_d;

    logic [WORD_W-1:0]      out_word_q, out_word_d;
    logic [LEN_W-1:0]       out_len_q, out_len_d;
    logic                   out_err_q, out_err_d;
    logic                   out_ovf_q, out_ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic                   dropped_q, dropped_d;

    logic                   is_dit, is_dah;
    logic [PULSE_CNT_W-1:0] char_thr, word_thr;
    logic                   char_pending;
    logic                   sym_fire, char_fire, word_fire, emit;
    logic [WORD_W-1:0]      cap_word;
    logic [LEN_W-1:0]       cap_len;
    logic                   cap_err, cap_ovf;
    logic [CHAR_W-1:0]      lut_char;
    logic                   lut_valid;

    morse_pattern_to_char #(
        .MAX_SYMBOLS(MAX_SYMBOLS)
    ) u_lut (
        .pattern  (pat_q),
        .count    (sym_cnt_q),
        .char_code(lut_char),
        .valid    (lut_valid)
    );

    assign is_dit       = abs_diff(mark_cnt_q, dit_time) <= {1'b0, tol_time};
    assign is_dah       = abs_diff(mark_cnt_q, dah_time) <= {1'b0, tol_time};
    assign char_thr     = gap_thr(dah_time, tol_time);
    assign word_thr     = gap_thr(word_time, tol_time);
    assign char_pending = (sym_cnt_q != '0) || char_err_q;

    always_comb begin
        state_d    = state_q;
        mark_cnt_d = mark_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pat_d      = pat_q;
        sym_cnt_d  = sym_cnt_q;
        char_err_d = char_err_q;
        acc_word_d = acc_word_q;
        acc_len_d  = acc_len_q;
        acc_err_d  = acc_err_q;
        acc_ovf_d  = acc_ovf_q;
        sym_fire   = 1'b0;
        char_fire  = 1'b0;
        word_fire  = 1'b0;
        emit       = 1'b0;
        cap_word   = '0;
        cap_len    = '0;
        cap_err    = 1'b0;
        cap_ovf    = 1'b0;

        if (ce) begin
            unique case (state_q)
                StIdle: begin
                    if (signal) begin
                        state_d    = StMark;
                        mark_cnt_d = PULSE_CNT_W'(1);
                    end
                end
                StMark: begin
                    if (signal) begin
                        mark_cnt_d = sat_inc(mark_cnt_q);
                    end else begin
                        state_d   = StSpace;
                        gap_cnt_d = PULSE_CNT_W'(1);
                        sym_fire  = 1'b1;
                    end
                end
                StSpace: begin
                    if (signal) begin
                        state_d    = StMark;
                        mark_cnt_d = PULSE_CNT_W'(1);
                    end else begin
                        gap_cnt_d = sat_inc(gap_cnt_q);
                        word_fire = (gap_cnt_q == word_thr);
                        // A word end also flushes a character still being assembled.
                        char_fire = char_pending && ((gap_cnt_q == char_thr) || word_fire);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (sym_fire) begin
            if (!is_dit && !is_dah) begin
                char_err_d = 1'b1;
            end else if (sym_cnt_q == SYM_W'(MAX_SYMBOLS)) begin
                char_err_d = 1'b1;
            end else begin
                pat_d     = (pat_q << 1) | MAX_SYMBOLS'(!is_dit);
                sym_cnt_d = sym_cnt_q + SYM_W'(1);
            end
        end

        if (char_fire) begin
            if (char_err_q || !lut_valid) begin
                acc_err_d = 1'b1;
            end else if (32'(acc_len_q) < MAX_CHARS) begin
                for (int i = 0; i < MAX_CHARS; i++) begin
                    if (acc_len_q == LEN_W'(i)) begin
                        acc_word_d[i*CHAR_W +: CHAR_W] = lut_char;
                    end
                end
                acc_len_d = acc_len_q + LEN_W'(1);
            end else begin
                acc_ovf_d = 1'b1;
            end
            pat_d      = '0;
            sym_cnt_d  = '0;
            char_err_d = 1'b0;
        end

        if (word_fire) begin
            state_d    = StIdle;
            emit       = (acc_len_d != '0) || acc_err_d || acc_ovf_d;
            cap_word   = acc_word_d;
            cap_len    = acc_len_d;
            cap_err    = acc_err_d;
            cap_ovf    = acc_ovf_d;
            acc_word_d = '0;
            acc_len_d  = '0;
            acc_err_d  = 1'b0;
            acc_ovf_d  = 1'b0;
        end
    end

    // Output holding register: a free or simultaneously drained slot takes the new word.
    always_comb begin
        out_word_d  = out_word_q;
        out_len_d   = out_len_q;
        out_err_d   = out_err_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        dropped_d   = 1'b0;
        if (emit) begin
            if (!out_valid_q || out_ready) begin
                out_word_d  = cap_word;
                out_len_d   = cap_len;
                out_err_d   = cap_err;
                out_ovf_d   = cap_ovf;
                out_valid_d = 1'b1;
            end else begin
                dropped_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mark_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pat_q       <= '0;
            sym_cnt_q   <= '0;
            char_err_q  <= 1'b0;
            acc_word_q  <= '0;
            acc_len_q   <= '0;
            acc_err_q   <= 1'b0;
            acc_ovf_q   <= 1'b0;
            out_word_q  <= '0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mark_cnt_q  <= mark_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pat_q       <= pat_d;
            sym_cnt_q   <= sym_cnt_d;
            char_err_q  <= char_err_d;
            acc_word_q  <= acc_word_d;
            acc_len_q   <= acc_len_d;
            acc_err_q   <= acc_err_d;
            acc_ovf_q   <= acc_ovf_d;
            out_word_q  <= out_word_d;
            out_len_q   <= out_len_d;
            out_err_q   <= out_err_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            dropped_q   <= dropped_d;
        end
    end

    assign word      = out_word_q;
    assign word_len  = out_len_q;
    assign word_err  = out_err_q;
    assign word_ovf  = out_ovf_q;
    assign out_valid = out_valid_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_morse_word_decoder_hs.sv
// Directed bench for morse_word_decoder_hs with DIT=10, DAH=30, WORD=70, TOL=5; a second
// instance with MAX_CHARS=4 covers word overflow.
module tb_morse_word_decoder_hs;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         signal;
    logic         out_ready;
    logic [15:0]  dit_time  = 16'd10;
    logic [15:0]  dah_time  = 16'd30;
    logic [15:0]  word_time = 16'd70;
    logic [15:0]  tol_time  = 16'd5;

    logic [127:0] word;
    logic [4:0]   word_len;
    logic         word_err, word_ovf, out_valid, dropped;
    logic [31:0]  word4;
    logic [2:0]   len4;
    logic         err4, ovf4, valid4, drop4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    morse_word_decoder_hs dut (
        .clk(clk), .rst(rst), .ce(ce), .signal(signal),
        .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time), .tol_time(tol_time),
        .word(word), .word_len(word_len), .word_err(word_err), .word_ovf(word_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .dropped(dropped)
    );

    morse_word_decoder_hs #(.MAX_CHARS(4)) dut4 (
        .clk(clk), .rst(rst), .ce(ce), .signal(signal),
        .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time), .tol_time(tol_time),
        .word(word4), .word_len(len4), .word_err(err4), .word_ovf(ovf4),
        .out_valid(valid4), .out_ready(out_ready), .dropped(drop4)
    );

    typedef struct {
        int         mark_len;
        logic [7:0] exp_char;
        logic [4:0] exp_len;
        logic       exp_err;
    } tol_vec_t;

    tol_vec_t tv [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic s);
        signal = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input string s);
        byte c, nx;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h20) continue;
            repeat ((c == 8'h2d) ? 30 : 10) step(1'b1);
            if (i + 1 < s.len()) begin
                nx = s[i+1];
                repeat ((nx == 8'h20) ? 30 : 10) step(1'b0);
            end
        end
    endtask

    // Counts gap ticks (the first low tick is 1) until out_valid is seen; -1 if it never rises.
    task automatic wait_word(output int ticks);
        ticks = -1;
        for (int k = 1; k <= 100; k++) begin
            step(1'b0);
            if (out_valid) begin
                ticks = k;
                break;
            end
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("accept_clears_valid", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           t;
        int           ndrop;
        logic [127:0] ew;

        rst = 1'b1; ce = 1'b0; signal = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {out_valid, word_len, word_err, word_ovf, dropped}, 0);
        chk("reset_word", word, 0);
        rst = 1'b0;
        ce  = 1'b1;

        // Single-mark words around the tolerance edges.
        tv[0] = '{15, 8'h45, 5'd1, 1'b0};
        tv[1] = '{16, 8'h00, 5'd0, 1'b1};
        tv[2] = '{25, 8'h54, 5'd1, 1'b0};
        tv[3] = '{5,  8'h45, 5'd1, 1'b0};
        tv[4] = '{4,  8'h00, 5'd0, 1'b1};
        tv[5] = '{35, 8'h54, 5'd1, 1'b0};
        tv[6] = '{36, 8'h00, 5'd0, 1'b1};
        tv[7] = '{10, 8'h45, 5'd1, 1'b0};
        tv[8] = '{30, 8'h54, 5'd1, 1'b0};
        tv[9] = '{24, 8'h00, 5'd0, 1'b1};
        for (int v = 0; v < 10; v++) begin
            repeat (tv[v].mark_len) step(1'b1);
            wait_word(t);
            ew = '0;
            if (tv[v].exp_len == 5'd1) ew[7:0] = tv[v].exp_char;
            chk($sformatf("tol%0d_valid_tick", tv[v].mark_len), t, 66);
            chk($sformatf("tol%0d_len", tv[v].mark_len), word_len, tv[v].exp_len);
            chk($sformatf("tol%0d_err", tv[v].mark_len), word_err, tv[v].exp_err);
            chk($sformatf("tol%0d_word", tv[v].mark_len), word, ew);
            accept();
        end

        // Basic word "ABC".
        send_code(".- -... -.-.");
        wait_word(t);
        chk("abc_valid_tick", t, 66);
        chk("abc_len", word_len, 3);
        chk("abc_word", word, 128'h434241);
        chk("abc_flags", {word_err, word_ovf, dropped}, 0);
        accept();

        // Overflow: "ABCDEF" into a 4-slot word.
        send_code(".- -... -.-. -.. . ..-.");
        wait_word(t);
        chk("ovf4_len", len4, 4);
        chk("ovf4_flag", ovf4, 1);
        chk("ovf4_word", word4, 32'h44434241);
        chk("ovf4_err", err4, 0);
        chk("ovf16_len", word_len, 6);
        chk("ovf16_word", word, 128'h464544434241);
        chk("ovf16_flag", word_ovf, 0);
        accept();

        // Backpressure: a second word arriving while the first is held is dropped once.
        send_code(".");
        wait_word(t);
        chk("bp_first_valid", t, 66);
        send_code("-");
        ndrop = 0;
        for (int k = 1; k <= 80; k++) begin
            step(1'b0);
            if (dropped) ndrop++;
        end
        chk("bp_drop_count", ndrop, 1);
        chk("bp_held_word", word, 128'h45);
        chk("bp_held_len_valid", {out_valid, word_len}, {1'b1, 5'd1});

        // Acceptance on the commit cycle itself loads the new word without a drop.
        send_code("-");
        ndrop = 0;
        for (int k = 1; k <= 70; k++) begin
            if (k == 66) out_ready = 1'b1;
            step(1'b0);
            if (k == 66) begin
                out_ready = 1'b0;
                chk("bp_same_cycle_valid", out_valid, 1);
                chk("bp_same_cycle_word", word, 128'h54);
            end
            if (dropped) ndrop++;
        end
        chk("bp_same_cycle_no_drop", ndrop, 0);
        accept();

        // Frozen ce mid-gap: no commit while frozen, gap resumes where it stopped.
        send_code(".");
        repeat (30) step(1'b0);
        ce = 1'b0;
        ndrop = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b0);
            if (out_valid) ndrop++;
        end
        chk("freeze_no_commit", ndrop, 0);
        ce = 1'b1;
        wait_word(t);
        chk("freeze_resume_tick", t, 36);
        chk("freeze_word", word, 128'h45);

        // Reset mid-mark with a word still held: everything clears at once.
        repeat (5) step(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_flags", {out_valid, word_len, word_err, word_ovf, dropped}, 0);
        chk("midrst_word", word, 0);
        signal = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_code(".");
        wait_word(t);
        chk("post_rst_tick", t, 66);
        chk("post_rst_len", word_len, 1);
        chk("post_rst_word", word, 128'h45);
        chk("post_rst_flags", {word_err, word_ovf}, 0);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
